// File: rtl/grid_pkg.sv
// Shared grid constants, row_bias FSM state type, LFSR taps and one-hot helpers.
// GRID_LEN comes from the `GRID_LEN macro and defaults to 9.
`ifndef GRID_LEN
`define GRID_LEN 9
`endif

package grid_pkg;

  localparam int GRID_LEN_P = `GRID_LEN;
  localparam int IDX_W      = $clog2(GRID_LEN_P);

  typedef enum logic [1:0] {
    SHUFFLE = 2'd0,
    SWAP    = 2'd1,
    READY   = 2'd2
  } row_bias_fsm_state;

  // Galois taps for x^16+x^14+x^13+x^11+1, right-shifting form
  localparam logic [15:0] LFSR_TAPS     = 16'hB400;
  localparam logic [15:0] LFSR_ZERO_SUB = 16'hACE1;

  function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [GRID_LEN_P:0] oh);
    logic [IDX_W-1:0] idx;
    idx = {IDX_W{1'b0}};
    for (int k = 0; k < GRID_LEN_P; k++) begin
      if (oh[k]) idx = IDX_W'(k);
      else       idx = idx;
    end
    return idx;
  endfunction

  function automatic logic is_entry_select(input logic [GRID_LEN_P:0] oh);
    return $onehot(oh) && !oh[GRID_LEN_P];
  endfunction

endpackage

// File: rtl/lfsr_galois.sv
// Right-shifting Galois LFSR; a zero seed is replaced so the register never locks up.
module lfsr_galois
  import grid_pkg::*;
#(
  parameter int LFSR_W = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [LFSR_W-1:0] seed,
  input  logic              advance,
  output logic [LFSR_W-1:0] value
);

  localparam logic [LFSR_W-1:0] TAPS = LFSR_W'(LFSR_TAPS);
  localparam logic [LFSR_W-1:0] SUB  = LFSR_W'(LFSR_ZERO_SUB);

  logic [LFSR_W-1:0] r_value;

  // Seed load on reset, one Galois step per advance
  always_ff @(posedge clock) begin
    if (reset) begin
      r_value <= (seed == {LFSR_W{1'b0}}) ? SUB : seed;
    end else if (advance) begin
      r_value <= {1'b0, r_value[LFSR_W-1:1]} ^ (r_value[0] ? TAPS : {LFSR_W{1'b0}});
    end else begin
      r_value <= r_value;
    end
  end

  assign value = r_value;

endmodule

// File: rtl/row_bias.sv
// Per-row shuffled one-hot value source feeding each tile's rowbias input.
// Optional ROW_BIAS_RESHUFFLE_EN adds a reshuffle input that restarts the shuffle from READY.
`ifndef GRID_LEN
`define GRID_LEN 9
`endif

module row_bias
  import grid_pkg::*;
#(
  parameter int GRID_LEN = `GRID_LEN,
  parameter int LFSR_W   = 16
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [LFSR_W-1:0]   seed,
  input  logic [GRID_LEN:0]   rqindex,
  input  logic                updaterowbias,
`ifdef ROW_BIAS_RESHUFFLE_EN
  input  logic                reshuffle,
`endif
  output logic [GRID_LEN-1:0] rowbias,
  output logic                ready
);

  localparam int IW = $clog2(GRID_LEN);

  row_bias_fsm_state  r_state, w_next;
  logic [GRID_LEN-1:0] r_entry [GRID_LEN];
  logic [IW-1:0]       r_i, r_j;
  logic [GRID_LEN-1:0] r_rowbias;
  logic                r_ready;
  logic [LFSR_W-1:0]   w_lfsr;
  logic [IW-1:0]       w_draw;
  logic                w_advance, w_restart;
  logic [GRID_LEN-1:0] w_sel;

  lfsr_galois #(.LFSR_W(LFSR_W)) u_lfsr (
    .clock   (clock),
    .reset   (reset),
    .seed    (seed),
    .advance (w_advance),
    .value   (w_lfsr)
  );

  assign w_draw = w_lfsr[IW-1:0];

  // FSM state register
  always_ff @(posedge clock) begin
    if (reset) r_state <= SHUFFLE;
    else       r_state <= w_next;
  end

  // Next state, LFSR advance and restart decode; draws above i are rejected
  always_comb begin
    w_next    = r_state;
    w_advance = 1'b0;
    w_restart = 1'b0;
    case (r_state)
      SHUFFLE: begin
        w_advance = 1'b1;
        if (r_i == {IW{1'b0}})  w_next = READY;
        else if (w_draw <= r_i) w_next = SWAP;
        else                    w_next = SHUFFLE;
      end
      SWAP:  w_next = SHUFFLE;
      READY: begin
`ifdef ROW_BIAS_RESHUFFLE_EN
        if (reshuffle) begin
          w_next    = SHUFFLE;
          w_restart = 1'b1;
        end else begin
          w_next = READY;
        end
`else
        w_next = READY;
`endif
      end
      default: w_next = SHUFFLE;
    endcase
  end

  // Entry lookup; zero, multi-hot or exhausted selects yield no candidate
  always_comb begin
    w_sel = {GRID_LEN{1'b0}};
    if (is_entry_select(rqindex)) w_sel = r_entry[onehot_to_idx(rqindex)];
    else                          w_sel = {GRID_LEN{1'b0}};
  end

  // Permutation, shuffle index and registered outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int k = 0; k < GRID_LEN; k++) begin
        r_entry[k] <= {{(GRID_LEN-1){1'b0}}, 1'b1} << k;
      end
      r_i       <= IW'(GRID_LEN - 1);
      r_j       <= {IW{1'b0}};
      r_rowbias <= {GRID_LEN{1'b0}};
      r_ready   <= 1'b0;
    end else begin
      case (r_state)
        SHUFFLE: begin
          if (w_next == SWAP) r_j <= w_draw;
          else                r_j <= r_j;
        end
        SWAP: begin
          r_entry[r_i] <= r_entry[r_j];
          r_entry[r_j] <= r_entry[r_i];
          r_i          <= r_i - {{(IW-1){1'b0}}, 1'b1};
        end
        READY: begin
          if (w_restart) begin
            r_i       <= IW'(GRID_LEN - 1);
            r_rowbias <= {GRID_LEN{1'b0}};
          end else if (updaterowbias) begin
            r_rowbias <= w_sel;
          end else begin
            r_rowbias <= r_rowbias;
          end
        end
        default: r_rowbias <= {GRID_LEN{1'b0}};
      endcase
      r_ready <= (w_next == READY);
    end
  end

  assign rowbias = r_rowbias;
  assign ready   = r_ready;

endmodule

// File: tb/tb_row_bias.sv
// Directed self-checking bench for row_bias; covers the reshuffle path when
// ROW_BIAS_RESHUFFLE_EN is defined.
module tb_row_bias;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] seed = 16'h0001;
  logic [9:0]  rqindex = 10'h000;
  logic        updaterowbias = 1'b0;
`ifdef ROW_BIAS_RESHUFFLE_EN
  logic        reshuffle = 1'b0;
`endif
  logic [8:0]  rowbias;
  logic        ready;

  int tests = 0;
  int fails = 0;
  int ncyc;
  logic [8:0] got   [9];
  logic [8:0] run_a [9];
  logic [8:0] run_b [9];
  // seed 1: draws are 1,0,0,... so swaps are (8,1),(7,0),(6,0)...(1,0)
  logic [8:0] exp1 [9] = '{9'h100, 9'h004, 9'h008, 9'h010, 9'h020,
                           9'h040, 9'h080, 9'h001, 9'h002};

  always #5 clock = ~clock;

  row_bias #(.GRID_LEN(9), .LFSR_W(16)) dut (
    .clock         (clock),
    .reset         (reset),
    .seed          (seed),
    .rqindex       (rqindex),
    .updaterowbias (updaterowbias),
`ifdef ROW_BIAS_RESHUFFLE_EN
    .reshuffle     (reshuffle),
`endif
    .rowbias       (rowbias),
    .ready         (ready)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic apply_reset(input logic [15:0] s);
    @(negedge clock);
    seed  = s;
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (ready !== 1'b1 && n < 300) begin
      @(negedge clock);
      n++;
    end
    chk("ready_reached", {31'd0, ready}, 32'd1);
  endtask

  task automatic request(input logic [9:0] idx);
    @(negedge clock);
    rqindex       = idx;
    updaterowbias = 1'b1;
    @(negedge clock);
    updaterowbias = 1'b0;
  endtask

  task automatic read_perm();
    for (int n = 0; n < 9; n++) begin
      request(10'h001 << n);
      got[n] = rowbias;
      @(negedge clock);
    end
  endtask

  task automatic check_perm(input string tag);
    logic [8:0] acc;
    acc = 9'h000;
    for (int n = 0; n < 9; n++) begin
      chk({tag, "_onehot"}, {31'd0, $onehot(got[n])}, 32'd1);
      acc = acc | got[n];
    end
    chk({tag, "_or"}, {23'd0, acc}, {23'd0, 9'h1FF});
  endtask

  initial begin
    // Reset state and seed 1 permutation, with a request while not ready
    apply_reset(16'h0001);
    chk("rst_rowbias", {23'd0, rowbias}, 32'd0);
    chk("rst_ready", {31'd0, ready}, 32'd0);
    request(10'h001);
    chk("notready_rowbias", {23'd0, rowbias}, 32'd0);
    chk("notready_ready", {31'd0, ready}, 32'd0);
    wait_ready(ncyc);
    chk("ready_within_64", {31'd0, (ncyc + 2) <= 64}, 32'd1);
    read_perm();
    for (int n = 0; n < 9; n++) chk("seed1_entry", {23'd0, got[n]}, {23'd0, exp1[n]});
    check_perm("seed1");

    // Latency of exactly one clock, then hold with updaterowbias low
    @(negedge clock);
    rqindex       = 10'h001;
    updaterowbias = 1'b1;
    chk("lat_before_edge", {23'd0, rowbias}, {23'd0, 9'h002});
    @(posedge clock);
    #1;
    chk("lat_after_edge", {23'd0, rowbias}, {23'd0, 9'h100});
    @(negedge clock);
    updaterowbias = 1'b0;
    rqindex       = 10'h002;
    repeat (3) @(negedge clock);
    chk("hold", {23'd0, rowbias}, {23'd0, 9'h100});

    // Exhausted, multi-hot and zero selects
    request(10'h200);
    chk("exhausted", {23'd0, rowbias}, 32'd0);
    request(10'h004);
    chk("entry2", {23'd0, rowbias}, {23'd0, 9'h008});
    request(10'h003);
    chk("multihot", {23'd0, rowbias}, 32'd0);
    request(10'h008);
    chk("entry3", {23'd0, rowbias}, {23'd0, 9'h010});
    request(10'h000);
    chk("zero_sel", {23'd0, rowbias}, 32'd0);

    // Simultaneous reset and request: reset wins; then seed BEEF twice
    request(10'h010);
    chk("entry4", {23'd0, rowbias}, {23'd0, 9'h020});
    @(negedge clock);
    seed          = 16'hBEEF;
    rqindex       = 10'h010;
    updaterowbias = 1'b1;
    reset         = 1'b1;
    @(negedge clock);
    reset         = 1'b0;
    updaterowbias = 1'b0;
    chk("rst_vs_upd_rowbias", {23'd0, rowbias}, 32'd0);
    chk("rst_vs_upd_ready", {31'd0, ready}, 32'd0);
    wait_ready(ncyc);
    read_perm();
    check_perm("beef_a");
    run_a = got;
    apply_reset(16'hBEEF);
    wait_ready(ncyc);
    read_perm();
    run_b = got;
    for (int n = 0; n < 9; n++) chk("beef_repeat", {23'd0, run_b[n]}, {23'd0, run_a[n]});

    // Zero seed behaves like ACE1
    apply_reset(16'h0000);
    wait_ready(ncyc);
    read_perm();
    check_perm("seed0");
    run_a = got;
    apply_reset(16'hACE1);
    wait_ready(ncyc);
    read_perm();
    run_b = got;
    for (int n = 0; n < 9; n++) chk("seed0_vs_ace1", {23'd0, run_b[n]}, {23'd0, run_a[n]});

    // Reset mid-shuffle restarts cleanly with the new seed
    apply_reset(16'h1234);
    wait_ready(ncyc);
    read_perm();
    run_a = got;
    apply_reset(16'h5555);
    repeat (2) @(negedge clock);
    seed  = 16'h1234;
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    chk("midrst_ready", {31'd0, ready}, 32'd0);
    chk("midrst_rowbias", {23'd0, rowbias}, 32'd0);
    seed = 16'h7777;
    wait_ready(ncyc);
    read_perm();
    run_b = got;
    for (int n = 0; n < 9; n++) chk("midrst_match", {23'd0, run_b[n]}, {23'd0, run_a[n]});

`ifdef ROW_BIAS_RESHUFFLE_EN
    // Reshuffle from READY drops ready and rebuilds a valid permutation
    request(10'h001);
    @(negedge clock);
    reshuffle = 1'b1;
    @(negedge clock);
    reshuffle = 1'b0;
    chk("resh_ready_1", {31'd0, ready}, 32'd0);
    chk("resh_rowbias", {23'd0, rowbias}, 32'd0);
    @(negedge clock);
    chk("resh_ready_2", {31'd0, ready}, 32'd0);
    wait_ready(ncyc);
    read_perm();
    check_perm("resh");
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
